stage_wb_mlane: RTL

- Parametrised successor to the single-issue writeback stage: registers NUM_LANES retiring results from the MEM2 stage.
- Adds stall/flush handshake, load byte/half extraction with sign/zero extension, same-rd lane arbitration and a per-lane hazard packet.
- Sits between MEM2 and the register-file write ports. Feeds the hazard unit through hazard_interface.

---
 rtl/stage_wb_mlane_pkg.sv | 17 +
 rtl/hazard_interface.sv | 7 +
 rtl/stage_wb_mlane_load_align.sv | 23 ++
 rtl/stage_wb_mlane.sv | 95 +++++++++
 4 files changed

// File: rtl/stage_wb_mlane_pkg.sv
// stage_wb_mlane_pkg: shared control, result-select and load-size types for the multi-lane writeback stage
package stage_wb_mlane_pkg;
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
  } control_signal_t;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_size_t;
endpackage

// File: rtl/hazard_interface.sv
// hazard_interface: per-lane writeback destination/write-enable packet towards the hazard unit
interface hazard_interface #(parameter int NUM_LANES = 2);
  logic [NUM_LANES-1:0][4:0] rd_w;
  logic [NUM_LANES-1:0]      regwrite_w;
  modport requester (output rd_w, regwrite_w);
  modport hazard_unit (input rd_w, regwrite_w);
endinterface

// File: rtl/stage_wb_mlane_load_align.sv
// wb_load_align: picks the byte/halfword of an aligned load word and sign/zero extends it
module wb_load_align
  import stage_wb_mlane_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    data = (funct3 == LB)  ? {{(XLEN-8){b[7]}}, b} :
           (funct3 == LBU) ? {{(XLEN-8){1'b0}}, b} :
           (funct3 == LH)  ? {{(XLEN-16){h[15]}}, h} :
           (funct3 == LHU) ? {{(XLEN-16){1'b0}}, h} :
                             XLEN'(word[31:0]);
  end
endmodule

// File: rtl/stage_wb_mlane.sv
// stage_wb_mlane: multi-lane MEM2->WB register stage with load extraction and same-rd arbitration
// Optional retire counter enabled by defining STAGE_WB_RETIRE_CNT_EN.
module stage_wb_mlane
  import stage_wb_mlane_pkg::*;
#(
  parameter int NUM_LANES    = 2,
  parameter int XLEN         = 32,
  parameter int RETIRE_CNT_W = 64
) (
  input  logic                                clk,
  input  logic                                start,
  input  logic                                stall_w,
  input  logic                                flush_w,
  input  logic [NUM_LANES-1:0]                valid_m2,
  input  control_signal_t [NUM_LANES-1:0]     control_signal_m2,
  input  logic [NUM_LANES-1:0][4:0]           rd_m2,
  input  logic [NUM_LANES-1:0][2:0]           funct3_m2,
  input  logic [NUM_LANES-1:0][1:0]           addr_lo_m2,
  input  logic [NUM_LANES-1:0][XLEN-1:0]      memresult_m2,
  input  logic [NUM_LANES-1:0][XLEN-1:0]      result_m2,
  output logic [NUM_LANES-1:0]                valid_w,
  output logic [NUM_LANES-1:0]                regwrite_w,
  output logic [NUM_LANES-1:0][4:0]           rd_w,
  output logic [NUM_LANES-1:0][XLEN-1:0]      result_w,
`ifdef STAGE_WB_RETIRE_CNT_EN
  output logic [RETIRE_CNT_W-1:0]             retire_cnt,
`endif
  hazard_interface.requester                  hazard_bus
);
  typedef struct packed {
    logic            valid;
    control_signal_t ctrl;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] memresult;
    logic [XLEN-1:0] result;
  } wb_lane_t;
  wb_lane_t [NUM_LANES-1:0]       lane_d, lane_q;
  logic [NUM_LANES-1:0][XLEN-1:0] load_data;
  logic [NUM_LANES-1:0]           qual;
  always_comb begin
    lane_d = '0;
    for (int i = 0; i < NUM_LANES; i++)
      lane_d[i] = flush_w     ? '0 :
                  stall_w     ? lane_q[i] :
                  valid_m2[i] ? wb_lane_t'{1'b1, control_signal_m2[i], rd_m2[i], funct3_m2[i],
                                           addr_lo_m2[i], memresult_m2[i], result_m2[i]} : '0;
  end
  always_ff @(posedge clk or negedge start)
    if (!start) lane_q <= '0;
    else lane_q <= lane_d;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    wb_load_align #(.XLEN(XLEN)) u_align (
      .funct3 (lane_q[i].funct3),
      .addr_lo(lane_q[i].addr_lo),
      .word   (lane_q[i].memresult),
      .data   (load_data[i])
    );
  end
  // an older lane loses its write when any younger lane writes the same rd
  always_comb begin
    valid_w    = '0;
    rd_w       = '0;
    result_w   = '0;
    qual       = '0;
    regwrite_w = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      valid_w[i]  = lane_q[i].valid;
      rd_w[i]     = lane_q[i].rd;
      result_w[i] = (lane_q[i].ctrl.resultsrc == RESULT_MEM) ? load_data[i] : lane_q[i].result;
      qual[i]     = lane_q[i].valid & lane_q[i].ctrl.regwrite & (lane_q[i].rd != 5'd0);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      regwrite_w[i] = qual[i];
      for (int j = i + 1; j < NUM_LANES; j++)
        regwrite_w[i] = regwrite_w[i] & ~(qual[j] & (rd_w[j] == rd_w[i]));
    end
  end
  assign hazard_bus.rd_w       = rd_w;
  assign hazard_bus.regwrite_w = regwrite_w;
`ifdef STAGE_WB_RETIRE_CNT_EN
  // a bundle is counted on the edge that moves it out of W, so a stall counts it once
  logic [RETIRE_CNT_W-1:0] retire_cnt_d, retire_cnt_q;
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    for (int i = 0; i < NUM_LANES; i++)
      retire_cnt_d = retire_cnt_d + RETIRE_CNT_W'(valid_w[i] & (flush_w | ~stall_w));
  end
  always_ff @(posedge clk or negedge start)
    if (!start) retire_cnt_q <= '0;
    else retire_cnt_q <= retire_cnt_d;
  assign retire_cnt = retire_cnt_q;
`endif
endmodule
